prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//   Writer side of the SoC instruction-memory image path. Receives a byte stream (host/UART/debug
//   bridge), assembles little-endian 32-bit words, and writes them to instruction memory at
//   BASE_ADDR, BASE_ADDR+4, ... so the fetch PC (resets to 0, steps +4) reads the program back.
//   Sits between the byte-stream front end and the imem write port.
// PARAMETERS
//   ADDR_W       32  width of mem_addr (byte address)
//   DEPTH_WORDS  64  imem capacity in words; longer loads are rejected
//   BASE_ADDR    0   byte address of first written word (multiple of 4)
// PORTS
//   clk            in   1       clock
//   rst            in   1       synchronous reset, active-high
//   start          in   1       begin a load; sampled only in IDLE
//   len_words      in   16      number of words to load, latched on accepted start
//   s_valid        in   1       byte stream valid
//   s_data         in   8       byte stream data
//   s_ready        out  1       loader accepts byte this cycle
//   mem_we         out  1       write request to imem
//   mem_addr       out  ADDR_W  byte address of write
//   mem_wdata      out  32      write data
//   mem_ready      in   1       imem accepts write when mem_we & mem_ready
//   busy           out  1       load in progress (not IDLE)
//   done           out  1       one-cycle pulse: load finished
//   err_len        out  1       one-cycle pulse: start rejected, len_words > DEPTH_WORDS
//   words_written  out  16      count of words written in current/last load
//   cksum_err      out  1       checksum mismatch (sticky until next start); 0 without CHECKSUM_EN
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; mem_addr=BASE_ADDR; byte lane and word buffer cleared.
//   FSM IDLE -> COLLECT -> WRITE -> (COLLECT | CHECK | DONE) -> IDLE.
//   IDLE: s_ready=0. start & len_words==0 -> DONE (no writes). start & len_words>DEPTH_WORDS ->
//     err_len pulse next cycle, stay IDLE. Otherwise latch len, words_written=0,
//     mem_addr=BASE_ADDR, cksum_err=0, -> COLLECT.
//   COLLECT: s_ready=1. Byte accepted on s_valid&s_ready goes to lane byte_idx (byte 0 = bits 7:0).
//     4th byte -> WRITE next cycle; s_ready drops the cycle after the 4th byte (never 5 in a row).
//   WRITE: mem_we=1, mem_addr/mem_wdata held stable until mem_ready; s_ready=0.
//     On accept: mem_addr+=4, words_written+=1; if last word -> CHECK (CHECKSUM_EN) or DONE,
//     else -> COLLECT. Write latency: first WRITE cycle follows the cycle the 4th byte is taken.
//   DONE: done=1 for exactly one cycle, busy=0 next cycle, -> IDLE.
//   start while busy: ignored. s_valid outside COLLECT/CHECK: ignored (not consumed).
//   mem_addr wraps modulo 2^ADDR_W (unreachable while len<=DEPTH_WORDS and BASE_ADDR aligned).
//   rst mid-load: immediate return to IDLE, partial word discarded, no further mem_we.
// CONFIGURATION
//   PROG_LOADER_CHECKSUM_EN defined: after last word, state CHECK accepts one extra byte; the
//     8-bit sum of all data bytes plus this byte must be 0x00, else cksum_err=1; -> DONE.
//   Undefined: no CHECK state, no checksum byte consumed, cksum_err tied 0.
// STRUCTURE
//   Package prog_loader_pkg: state encoding (IDLE, COLLECT, WRITE, CHECK, DONE), BYTES_PER_WORD=4,
//     WORD_W=32, LEN_W=16.
//   Sub-module word_assembler: byte-lane counter + 32-bit buffer, outputs word_valid on 4th byte,
//     clear input; top holds FSM, address/count registers, checksum.
// TESTING
//   1 Reset: rst high 2 cycles -> all outputs 0, mem_addr=0, s_ready=0.
//   2 start, len=2, bytes 93 00 50 00 13 00 00 00, mem_ready=1 -> writes (0,0x00500093),
//     (4,0x00000013); words_written=2; done pulse one cycle; busy 0 after.
//   3 mem_ready low 3 cycles during WRITE -> mem_we/addr/wdata stable, s_ready=0, no byte lost.
//   4 s_valid gaps between bytes (1-3 idle cycles) -> same words as scenario 2.
//   5 len=65 (DEPTH_WORDS=64) -> err_len pulse, no mem_we; len=0 -> done pulse, no mem_we.
//   6 rst after 2 bytes of word 0 -> IDLE; new load len=1 writes addr 0 with fresh 4 bytes only.
//   7 CHECKSUM_EN, len=1, bytes 93 00 50 00 + 1D -> cksum_err=0; with 1E -> cksum_err=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: FSM state
// encoding, word/byte geometry and the length-limit helper.
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int LEN_W          = 16;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // True when a requested load does not fit in instruction memory.
    function automatic logic len_exceeds(input logic [LEN_W-1:0] len,
                                         input int unsigned      depth);
        return 32'(len) > depth;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus bundle: load command, byte stream, imem write port and status.
// The master modport is the host/memory side, the slave modport is the loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic                start;
    logic [LEN_W-1:0]    len_words;
    logic                s_valid;
    logic [BYTE_W-1:0]   s_data;
    logic                s_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic                err_len;
    logic [LEN_W-1:0]    words_written;
    logic                cksum_err;

    modport master (
        output start, len_words, s_valid, s_data, mem_ready,
        input  s_ready, mem_we, mem_addr, mem_wdata,
               busy, done, err_len, words_written, cksum_err
    );

    modport slave (
        input  start, len_words, s_valid, s_data, mem_ready,
        output s_ready, mem_we, mem_addr, mem_wdata,
               busy, done, err_len, words_written, cksum_err
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Little-endian word assembler: drops each accepted byte into the next lane
// (lane 0 = bits 7:0) and flags the byte that completes a 32-bit word.
// The completed word stays in the buffer until further bytes arrive.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] buf_q,  buf_d;

    // Next lane index and buffer contents.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that left one unassigned would infer a latch.
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clear_i) begin
            lane_d = '0;
            buf_d  = '0;
        end else if (byte_valid_i) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    buf_d[i*BYTE_W +: BYTE_W] = byte_data_i;
                end
            end
            lane_d = lane_q + LANE_W'(1);
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i &&
                          (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_o       = buf_q;

    // Lane counter and word buffer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the buffer is a plain register (not a RAM macro) that drives mem_wdata, so it is reset like any flop.
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory image loader: assembles a byte stream into little-endian
// words and writes them to imem at BASE_ADDR, BASE_ADDR+4, ...
// Optional feature: define PROG_LOADER_CHECKSUM_EN to consume one trailing
// checksum byte per load and flag a non-zero 8-bit byte sum on cksum_err.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               ADDR_W      = 32,
    parameter int               DEPTH_WORDS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic              err_len_q, err_len_d;
    logic [LEN_W-1:0]  cnt_inc;

    logic              s_ready_c;
    logic              mem_we_c;
    logic              asm_clear;
    logic              asm_byte_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              cksum_err_q, cksum_err_d;
`endif

    // Only bytes taken while collecting a word go into the assembler.
    assign asm_byte_valid = bus.s_valid && (state_q == ST_COLLECT);
    assign cnt_inc        = cnt_q + LEN_W'(1);

    word_assembler u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_byte_valid),
        .byte_data_i  (bus.s_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state, datapath updates and handshake outputs of the load FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_len_d = 1'b0;
        s_ready_c = 1'b0;
        mem_we_c  = 1'b0;
        asm_clear = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        cksum_err_d = cksum_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (len_exceeds(bus.len_words, $unsigned(DEPTH_WORDS))) begin
                        err_len_d = 1'b1;
                    end else begin
                        len_d     = bus.len_words;
                        cnt_d     = '0;
                        addr_d    = BASE_ADDR;
                        asm_clear = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d       = '0;
                        cksum_err_d = 1'b0;
`endif
                        state_d = (bus.len_words == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                s_ready_c = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                if (bus.s_valid) begin
                    sum_d = sum_q + bus.s_data;
                end
`endif
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we_c = 1'b1;
                if (bus.mem_ready) begin
                    addr_d = addr_q + ADDR_W'(BYTES_PER_WORD);
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    cksum_err_d = ((sum_q + bus.s_data) != '0);
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address, count and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= BASE_ADDR;
            cnt_q     <= '0;
            len_q     <= '0;
            err_len_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            err_len_q <= err_len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            cksum_err_q <= cksum_err_d;
`endif
        end
    end

    assign bus.s_ready       = s_ready_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = word;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.err_len       = err_len_q;
    assign bus.words_written = cnt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.cksum_err     = cksum_err_q;
`else
    assign bus.cksum_err     = 1'b0;
`endif

endmodule
